// File: rtl/seq_operator_pkg.sv
// Shared opcode/state types and the single-cycle operator evaluator for the
// sequential operator unit.
package seq_operator_pkg;

    // Widest operand the single-cycle evaluator is built for; instances use
    // the low WIDTH bits of it.
    localparam int MAX_WIDTH = 128;
    localparam int IDX_W     = $clog2(MAX_WIDTH);

    localparam logic [MAX_WIDTH-1:0] MAX_ONE  = {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MAX_WIDTH-1:0] MAX_ZERO = {MAX_WIDTH{1'b0}};
    localparam logic [MAX_WIDTH-1:0] MAX_ONES = {MAX_WIDTH{1'b1}};

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_XNOR = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_ASHR = 4'd11,
        OP_RAND = 4'd12,
        OP_ROR  = 4'd13,
        OP_RXOR = 4'd14,
        OP_LT   = 4'd15
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FIXUP  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Evaluate every operator except DIV/MOD on zero-extended operands of
    // 'width' significant bits. The result is masked to 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] eval_op(
        input op_e                  op,
        input logic                 sgn,
        input logic [MAX_WIDTH-1:0] a,
        input logic [MAX_WIDTH-1:0] b,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] mask;
        logic [MAX_WIDTH-1:0] res;
        logic [IDX_W-1:0]     msb_idx;
        logic                 a_msb;
        logic                 b_msb;
        logic                 fill;
        logic                 lt;
        logic                 big_shift;

        msb_idx = IDX_W'(width - 32'd1);
        if (width >= MAX_WIDTH) begin
            mask = MAX_ONES;
        end else begin
            mask = (MAX_ONE << width) - MAX_ONE;
        end
        a_msb     = a[msb_idx];
        b_msb     = b[msb_idx];
        fill      = sgn & a_msb;
        big_shift = (b >= MAX_WIDTH'(width));
        // Signed compare: differing sign bits decide directly.
        if (sgn && (a_msb != b_msb)) begin
            lt = a_msb;
        end else begin
            lt = (a < b);
        end

        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_XNOR: res = ~(a ^ b);
            OP_SHL:  res = big_shift ? MAX_ZERO : (a << b);
            OP_SHR:  res = big_shift ? MAX_ZERO : (a >> b);
            OP_ASHR: begin
                if (big_shift) begin
                    res = fill ? mask : MAX_ZERO;
                end else begin
                    res = (a >> b) | (fill ? (mask & ~(mask >> b)) : MAX_ZERO);
                end
            end
            OP_RAND: res = {{(MAX_WIDTH-1){1'b0}}, (a == mask)};
            OP_ROR:  res = {{(MAX_WIDTH-1){1'b0}}, (a != MAX_ZERO)};
            OP_RXOR: res = {{(MAX_WIDTH-1){1'b0}}, ^a};
            OP_LT:   res = {{(MAX_WIDTH-1){1'b0}}, lt};
            default: res = MAX_ZERO;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/seq_operator_checker.sv
// Protocol properties of the operator unit's result channel.
module seq_operator_checker
    import seq_operator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    input state_e           state,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] result
);

    // A presented result must not change until the consumer takes it.
    a_result_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(result));

    // An idle unit never claims to hold a result.
    a_no_valid_in_idle: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> !out_valid);

endmodule

// File: rtl/seq_operator_serial_divider.sv
// Restoring serial divider on unsigned magnitudes: one quotient bit per
// cycle, WIDTH cycles per division. Sign handling is left to the caller.
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_last,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvs;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // The partial remainder stays below the divisor, so WIDTH+1 bits hold
    // the shifted value and the trial subtraction without overflow.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    // Load on start, then shift in one quotient bit per cycle until the counter expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= {CW{1'b0}};
            r_quo  <= {WIDTH{1'b0}};
            r_rem  <= {WIDTH{1'b0}};
            r_dvs  <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(WIDTH - 1);
            r_quo  <= i_dividend;
            r_rem  <= {WIDTH{1'b0}};
            r_dvs  <= i_divisor;
        end else if (r_busy) begin
            r_quo  <= {r_quo[WIDTH-2:0], w_fits};
            r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_cnt  <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
            r_busy <= (r_cnt != {CW{1'b0}});
        end else begin
            r_busy <= r_busy;
        end
    end

    assign o_last      = r_busy & (r_cnt == {CW{1'b0}});
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

endmodule

// File: rtl/seq_operator_unit.sv
// Handshaked operator engine: single-cycle operators plus an iterative
// signed/unsigned divider for DIV and MOD.
module seq_operator_unit
    import seq_operator_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};

    state_e           r_state;
    state_e           w_next_state;
    op_e              r_op;
    logic             r_signed;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_result;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_div_in;
    logic             w_div_start;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_last;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_eval;
    logic [WIDTH-1:0] w_fix_result;
    logic             w_fix_dbz;

    assign w_accept    = in_valid & (r_state == ST_IDLE);
    assign w_is_div_in = (op == OP_DIV) | (op == OP_MOD);
    assign w_div_start = w_accept & w_is_div_in & (b != ZERO_W);

    // Magnitudes feed the divider straight from the accepted operands.
    assign w_a_neg = is_signed & a[WIDTH-1];
    assign w_b_neg = is_signed & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? ((~a) + ONE_W) : a;
    assign w_b_mag = w_b_neg ? ((~b) + ONE_W) : b;

    serial_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk         (clk),
        .rst         (rst),
        .i_start     (w_div_start),
        .i_dividend  (w_a_mag),
        .i_divisor   (w_b_mag),
        .o_last      (w_div_last),
        .o_quotient  (w_div_quo),
        .o_remainder (w_div_rem)
    );

    assign w_eval = WIDTH'(eval_op(r_op, r_signed, MAX_WIDTH'(r_a), MAX_WIDTH'(r_b), WIDTH));

    // Select the value latched in FIXUP: sign-corrected divider output,
    // the divide-by-zero convention, or the single-cycle operator result.
    always_comb begin
        w_fix_result = ZERO_W;
        w_fix_dbz    = 1'b0;
        if ((r_op == OP_DIV) || (r_op == OP_MOD)) begin
            if (r_b == ZERO_W) begin
                w_fix_dbz    = 1'b1;
                w_fix_result = (r_op == OP_DIV) ? ONES_W : r_a;
            end else if (r_op == OP_DIV) begin
                w_fix_result = r_neg_q ? ((~w_div_quo) + ONE_W) : w_div_quo;
            end else begin
                w_fix_result = r_neg_r ? ((~w_div_rem) + ONE_W) : w_div_rem;
            end
        end else begin
            w_fix_result = w_eval;
        end
    end

    // Next-state logic of the control FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_div_start) begin
                    w_next_state = ST_DIVIDE;
                end else if (w_accept) begin
                    w_next_state = ST_FIXUP;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DIVIDE: begin
                if (w_div_last) begin
                    w_next_state = ST_FIXUP;
                end else begin
                    w_next_state = ST_DIVIDE;
                end
            end
            ST_FIXUP: w_next_state = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register of the control FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the operation on acceptance so later input changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= OP_ADD;
            r_signed <= 1'b0;
            r_a      <= ZERO_W;
            r_b      <= ZERO_W;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_accept) begin
            r_op     <= op_e'(op);
            r_signed <= is_signed;
            r_a      <= a;
            r_b      <= b;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
        end else begin
            r_op     <= r_op;
        end
    end

    // Latch the final result once, in FIXUP, and hold it through DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= ZERO_W;
            r_dbz    <= 1'b0;
        end else if (r_state == ST_FIXUP) begin
            r_result <= w_fix_result;
            r_dbz    <= w_fix_dbz;
        end else begin
            r_result <= r_result;
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign result      = r_result;
    assign div_by_zero = r_dbz;

    seq_operator_checker #(
        .WIDTH (WIDTH)
    ) u_checker (
        .clk       (clk),
        .rst       (rst),
        .state     (r_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (r_result)
    );

endmodule

// File: tb/tb_seq_operator_unit.sv
// Self-checking bench: a WIDTH=32 and a WIDTH=4 instance driven by directed
// and random operations, checked against an arithmetic reference model.
module tb_seq_operator_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        iv32, ir32, sg32, ov32, or32, dz32;
    logic [3:0]  op32;
    logic [31:0] a32, b32, r32;

    logic        iv4, ir4, sg4, ov4, or4, dz4;
    logic [3:0]  op4, a4, b4, r4;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    seq_operator_unit #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .op(op32),
        .is_signed(sg32), .a(a32), .b(b32), .out_valid(ov32), .out_ready(or32),
        .result(r32), .div_by_zero(dz32)
    );

    seq_operator_unit #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op4),
        .is_signed(sg4), .a(a4), .b(b4), .out_valid(ov4), .out_ready(or4),
        .result(r4), .div_by_zero(dz4)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: operator semantics from plain integer arithmetic.
    function automatic logic [31:0] model(input int w, input int o, input bit s,
                                          input logic [31:0] a, input logic [31:0] b,
                                          output bit dz);
        longint unsigned mask, ua, ub, r;
        longint sa, sb, q;
        mask = (longint'(1) << w) - 1;
        ua = a & mask;
        ub = b & mask;
        sa = (s && ua[w-1]) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = (s && ub[w-1]) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        dz = 1'b0;
        r  = 0;
        case (o)
            0:  r = ua + ub;
            1:  r = ua - ub;
            2:  r = ua * ub;
            3, 4: begin
                if (ub == 0) begin
                    dz = 1'b1;
                    r  = (o == 3) ? mask : ua;
                end else if (s) begin
                    q = (o == 3) ? sa / sb : sa % sb;
                    r = q;
                end else begin
                    r = (o == 3) ? ua / ub : ua % ub;
                end
            end
            5:  r = ua & ub;
            6:  r = ua | ub;
            7:  r = ua ^ ub;
            8:  r = ~(ua ^ ub);
            9:  r = (ub >= longint'(w)) ? 0 : ua << ub;
            10: r = (ub >= longint'(w)) ? 0 : ua >> ub;
            11: begin
                if (!s) r = (ub >= longint'(w)) ? 0 : ua >> ub;
                else if (ub >= longint'(w)) r = (sa < 0) ? mask : 0;
                else begin
                    q = sa >>> ub;
                    r = q;
                end
            end
            12: r = (ua == mask) ? 1 : 0;
            13: r = (ua != 0) ? 1 : 0;
            14: r = longint'($countones(ua) % 2);
            15: r = s ? ((sa < sb) ? 1 : 0) : ((ua < ub) ? 1 : 0);
            default: r = 0;
        endcase
        return 32'(r & mask);
    endfunction

    task automatic drive(input int w, input logic v, input logic [3:0] o, input logic s,
                         input logic [31:0] av, input logic [31:0] bv);
        if (w == 32) begin
            iv32 = v; op32 = o; sg32 = s; a32 = av; b32 = bv;
        end else begin
            iv4 = v; op4 = o; sg4 = s; a4 = av[3:0]; b4 = bv[3:0];
        end
    endtask

    task automatic set_ready(input int w, input logic v);
        if (w == 32) or32 = v;
        else or4 = v;
    endtask

    task automatic sample(input int w, output logic ov, output logic ir, output logic dz,
                          output logic [31:0] res);
        if (w == 32) begin
            ov = ov32; ir = ir32; dz = dz32; res = r32;
        end else begin
            ov = ov4; ir = ir4; dz = dz4; res = {28'd0, r4};
        end
    endtask

    // One complete transaction: offer, measure latency, check, hold, release.
    task automatic run_op(input int w, input int o, input bit s,
                          input logic [31:0] av, input logic [31:0] bv,
                          input int hold, input bit has_want, input logic [31:0] want,
                          input string tag);
        logic [31:0] avm, bvm, exp_r, res;
        bit          exp_dz;
        int          exp_lat, n;
        logic        ov, ir, dz;
        avm = (w == 32) ? av : (av & 32'hF);
        bvm = (w == 32) ? bv : (bv & 32'hF);
        exp_r = model(w, o, s, avm, bvm, exp_dz);
        if (has_want) exp_r = want;
        exp_lat = (((o == 3) || (o == 4)) && (bvm != 32'd0)) ? (w + 1) : 1;

        @(negedge clk);
        drive(w, 1'b1, 4'(o), s, avm, bvm);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 4'($urandom), 1'($urandom), $urandom, $urandom);
        n  = 0;
        ov = 1'b0;
        while (!ov && (n < 200)) begin
            @(posedge clk);
            #1;
            n++;
            sample(w, ov, ir, dz, res);
        end
        check({tag, "/latency"}, 32'(n), 32'(exp_lat));
        check({tag, "/result"}, res, exp_r);
        check({tag, "/div_by_zero"}, {31'd0, dz}, {31'd0, exp_dz});
        check({tag, "/in_ready_busy"}, {31'd0, ir}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            sample(w, ov, ir, dz, res);
            check({tag, "/hold_valid"}, {31'd0, ov}, 32'd1);
            check({tag, "/hold_result"}, res, exp_r);
            check({tag, "/hold_in_ready"}, {31'd0, ir}, 32'd0);
        end
        @(negedge clk);
        set_ready(w, 1'b1);
        @(posedge clk);
        #1;
        set_ready(w, 1'b0);
        sample(w, ov, ir, dz, res);
        check({tag, "/released_valid"}, {31'd0, ov}, 32'd0);
        check({tag, "/released_in_ready"}, {31'd0, ir}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ro, mode;
        rst = 1'b1;
        drive(32, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        drive(4, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        or32 = 1'b0;
        or4  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset/in_ready", {31'd0, ir32}, 32'd1);
        check("reset/out_valid", {31'd0, ov32}, 32'd0);
        check("reset/result", r32, 32'd0);
        check("reset/div_by_zero", {31'd0, dz32}, 32'd0);
        check("reset/result_w4", {28'd0, r4}, 32'd0);

        run_op(32, 0, 0, 32'd5, 32'd10, 0, 1, 32'd15, "add");
        run_op(32, 1, 0, 32'd5, 32'd10, 0, 1, 32'hFFFFFFFB, "sub");
        run_op(32, 2, 0, 32'd10, 32'd5, 0, 1, 32'd50, "mul");
        run_op(32, 3, 1, 32'd10, 32'hFFFFFFFB, 0, 1, 32'hFFFFFFFE, "div_signed");
        run_op(32, 4, 0, 32'd10, 32'd3, 0, 1, 32'd1, "mod_unsigned");
        run_op(32, 3, 0, 32'd7, 32'd0, 0, 1, 32'hFFFFFFFF, "div_by_zero");
        run_op(32, 4, 1, 32'hFFFFFFF9, 32'd0, 0, 1, 32'hFFFFFFF9, "mod_by_zero");
        run_op(32, 3, 1, 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'h80000000, "div_min_neg1");
        run_op(32, 4, 1, 32'h80000000, 32'hFFFFFFFF, 0, 1, 32'd0, "mod_min_neg1");
        run_op(32, 4, 1, 32'hFFFFFFF9, 32'd2, 0, 1, 32'hFFFFFFFF, "mod_neg_dividend");
        run_op(32, 9, 0, 32'd1, 32'd6, 0, 1, 32'd64, "shl");
        run_op(32, 11, 1, 32'hFFFFFFFE, 32'd1, 0, 1, 32'hFFFFFFFF, "ashr_signed");
        run_op(32, 11, 1, 32'hFFFFFFFF, 32'd40, 0, 1, 32'hFFFFFFFF, "ashr_big");
        run_op(32, 11, 0, 32'h80000000, 32'd4, 0, 1, 32'h08000000, "ashr_unsigned");
        run_op(32, 10, 0, 32'h80000000, 32'd32, 0, 1, 32'd0, "shr_width");
        run_op(4, 12, 0, 32'h9, 32'h0, 0, 1, 32'd0, "w4_rand");
        run_op(4, 13, 0, 32'h9, 32'h0, 0, 1, 32'd1, "w4_ror");
        run_op(4, 14, 0, 32'h9, 32'h0, 0, 1, 32'd0, "w4_rxor");
        run_op(4, 8, 0, 32'h1, 32'h9, 0, 1, 32'h7, "w4_xnor");
        run_op(4, 15, 1, 32'hE, 32'h1, 0, 1, 32'd1, "w4_lt_signed");
        run_op(4, 3, 1, 32'h8, 32'hF, 0, 1, 32'h8, "w4_div_min_neg1");
        run_op(32, 7, 0, 32'hA5A5A5A5, 32'h0F0F0F0F, 5, 0, 32'd0, "backpressure");

        // Reset in the middle of a divide.
        @(negedge clk);
        drive(32, 1'b1, 4'd3, 1'b0, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_div_reset/out_valid", {31'd0, ov32}, 32'd0);
        check("mid_div_reset/in_ready", {31'd0, ir32}, 32'd1);
        check("mid_div_reset/result", r32, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(32, 0, 0, 32'd1, 32'd1, 0, 1, 32'd2, "after_reset_add");

        // Random operations on both widths against the reference model.
        for (int i = 0; i < 120; i++) begin
            ro   = $urandom_range(0, 15);
            mode = $urandom_range(0, 4);
            ra   = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case (mode)
                0:       rb = $urandom;
                1:       rb = $urandom_range(0, 40);
                2:       rb = 32'd0;
                3:       rb = 32'hFFFFFFFF;
                default: rb = $urandom_range(1, 9);
            endcase
            run_op((i % 2 == 0) ? 32 : 4, ro, 1'($urandom), ra, rb,
                   $urandom_range(0, 2), 0, 32'd0, $sformatf("rand%0d_op%0d", i, ro));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
